// File: rtl/vid_strm_pkg.sv
// Shared constants for the AXI4-Stream video pattern source: FSM states,
// pattern encodings, colour-bar table and LFSR parameters.
package vid_strm_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_HBLANK = 2'd2;
    localparam logic [1:0] ST_VBLANK = 2'd3;

    localparam logic [2:0] PTN_HRAMP = 3'd0;
    localparam logic [2:0] PTN_VRAMP = 3'd1;
    localparam logic [2:0] PTN_CHECK = 3'd2;
    localparam logic [2:0] PTN_BARS  = 3'd3;
    localparam logic [2:0] PTN_MOVE  = 3'd4;

    localparam logic [15:0] PIX_FLAT  = 16'h8080;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 as a bit mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // RGB565 bars: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 16'hFFFF;
            3'd1:    bar_colour = 16'hFFE0;
            3'd2:    bar_colour = 16'h07FF;
            3'd3:    bar_colour = 16'h07E0;
            3'd4:    bar_colour = 16'hF81F;
            3'd5:    bar_colour = 16'hF800;
            3'd6:    bar_colour = 16'h001F;
            default: bar_colour = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/vid_ptn_pix.sv
// Combinational pixel generator: maps (pattern, x, y, frame round) to a
// 16-bit pixel value.
module vid_ptn_pix
    import vid_strm_pkg::*;
#(
    parameter int WDT = 640
) (
    input  logic [2:0]  ptn,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] frm,
    output logic [15:0] pix
);

    always_comb begin
        pix = PIX_FLAT;
        case (ptn)
            PTN_HRAMP: pix = x;
            PTN_VRAMP: pix = y;
            PTN_CHECK: pix = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
            PTN_BARS:  pix = bar_colour(3'(({16'd0, x} * 32'd8) / 32'(WDT)));
            PTN_MOVE:  pix = x + y + frm;
            default:   pix = PIX_FLAT;
        endcase
    end

endmodule

// File: rtl/vid_strm_gen.sv
// Parametrised AXI4-Stream video source with blanking, virtual channels and
// test patterns. Define VID_STRM_GEN_STALL_EN for LFSR-driven tvalid bubbles.
module vid_strm_gen
    import vid_strm_pkg::*;
#(
    parameter int WDT  = 640,
    parameter int HGT  = 480,
    parameter int DW   = 32,
    parameter int NCH  = 1,
    parameter int HBLK = 16,
    parameter int VBLK = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enb,
    input  logic [2:0]      ptn_sel,
    output logic            tvalid,
    input  logic            tready,
    output logic            tuser,
    output logic            tlast,
    output logic [DW-1:0]   tdata,
    output logic [3:0]      tdest,
    output logic [DW/8-1:0] tkeep,
    output logic            busy,
    output logic [15:0]     frm_cnt
);

    localparam int BMAX = (HBLK > VBLK) ? HBLK : VBLK;
    localparam int BW   = $clog2(BMAX + 2);
    localparam logic [BW-1:0] HB_LAST = BW'((HBLK > 0) ? HBLK - 1 : 0);
    localparam logic [BW-1:0] VB_LAST = BW'((VBLK > 0) ? VBLK - 1 : 0);
    localparam logic [15:0]   X_LAST  = 16'(WDT - 1);
    localparam logic [15:0]   Y_LAST  = 16'(HGT - 1);
    localparam logic [3:0]    CH_LAST = 4'(NCH - 1);

    logic [1:0]    state, ns;
    logic [15:0]   x, y, nx, ny;
    logic [3:0]    ch, nch;
    logic [BW-1:0] bcnt, nb;
    logic [2:0]    ptn, nptn;
    logic [15:0]   nfrm;
    logic [15:0]   pix;
    logic          load, frame_end, stall;

`ifdef VID_STRM_GEN_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Next-beat coordinates: the output register is loaded from these so the
    // presented beat always matches the state being entered.
    always_comb begin
        ns        = state;
        nx        = x;
        ny        = y;
        nch       = ch;
        nb        = bcnt;
        nfrm      = frm_cnt;
        nptn      = ptn;
        load      = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enb) begin
                    ns   = ST_ACTIVE;
                    nx   = '0;
                    ny   = '0;
                    nch  = '0;
                    nptn = ptn_sel;
                    load = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (tvalid && tready) begin
                    if (x != X_LAST) begin
                        nx   = x + 16'd1;
                        load = 1'b1;
                    end else if (y != Y_LAST) begin
                        if (HBLK == 0) begin
                            nx   = '0;
                            ny   = y + 16'd1;
                            load = 1'b1;
                        end else begin
                            ns = ST_HBLANK;
                            nb = '0;
                        end
                    end else if (VBLK == 0) begin
                        frame_end = 1'b1;
                    end else begin
                        ns = ST_VBLANK;
                        nb = '0;
                    end
                end
            end
            ST_HBLANK: begin
                if (bcnt == HB_LAST) begin
                    ns   = ST_ACTIVE;
                    nx   = '0;
                    ny   = y + 16'd1;
                    nb   = '0;
                    load = 1'b1;
                end else begin
                    nb = bcnt + BW'(1);
                end
            end
            default: begin
                if (bcnt == VB_LAST) frame_end = 1'b1;
                else                 nb = bcnt + BW'(1);
            end
        endcase

        if (frame_end) begin
            nch = (ch == CH_LAST) ? 4'd0 : ch + 4'd1;
            if (ch == CH_LAST) nfrm = frm_cnt + 16'd1;
            nx = '0;
            ny = '0;
            nb = '0;
            if (enb) begin
                ns   = ST_ACTIVE;
                nptn = ptn_sel;
                load = 1'b1;
            end else begin
                ns = ST_IDLE;
            end
        end
    end

    vid_ptn_pix #(.WDT(WDT)) u_pix (
        .ptn (nptn),
        .x   (nx),
        .y   (ny),
        .frm (nfrm),
        .pix (pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            x       <= '0;
            y       <= '0;
            ch      <= '0;
            bcnt    <= '0;
            ptn     <= '0;
            frm_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= ns;
            x       <= nx;
            y       <= ny;
            ch      <= nch;
            bcnt    <= nb;
            ptn     <= nptn;
            frm_cnt <= nfrm;
            busy    <= (ns != ST_IDLE);
        end
    end

    // A stalled beat is loaded with tvalid low and raised on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
            tuser  <= 1'b0;
            tlast  <= 1'b0;
            tdata  <= '0;
            tdest  <= '0;
            tkeep  <= '0;
        end else if (load) begin
            tvalid <= !stall;
            tuser  <= (nx == 16'd0) && (ny == 16'd0);
            tlast  <= (nx == X_LAST);
            tdata  <= {(DW/16){pix}};
            tdest  <= nch;
            tkeep  <= stall ? '0 : '1;
        end else if (state == ST_ACTIVE && !tvalid) begin
            tvalid <= 1'b1;
            tkeep  <= '1;
        end else if (tvalid && tready) begin
            tvalid <= 1'b0;
            tuser  <= 1'b0;
            tlast  <= 1'b0;
            tdata  <= '0;
            tdest  <= '0;
            tkeep  <= '0;
        end
    end

endmodule

// File: tb/tb_vid_strm_gen.sv
// Scoreboard bench: a frame-level reference model queues expected beats,
// monitors pop and compare on every handshake.
module tb_vid_strm_gen;

    localparam int WDT = 8, HGT = 4, DW = 32, NCH = 2, HBLK = 2, VBLK = 5;
    localparam int W2 = 16, H2 = 2, DW2 = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enb = 1'b0, tready = 1'b1;
    logic [2:0] ptn_sel = '0;
    logic tvalid, tuser, tlast, busy;
    logic [DW-1:0] tdata;
    logic [3:0] tdest;
    logic [DW/8-1:0] tkeep;
    logic [15:0] frm_cnt;

    logic enb2 = 1'b0, tready2 = 1'b1;
    logic [2:0] ptn2 = '0;
    logic tvalid2, tuser2, tlast2, busy2;
    logic [DW2-1:0] tdata2;
    logic [3:0] tdest2;
    logic [DW2/8-1:0] tkeep2;
    logic [15:0] frm_cnt2;

    always #5 clk = ~clk;

    vid_strm_gen #(.WDT(WDT), .HGT(HGT), .DW(DW), .NCH(NCH), .HBLK(HBLK), .VBLK(VBLK)) u_dut (
        .clk(clk), .rst_n(rst_n), .enb(enb), .ptn_sel(ptn_sel), .tvalid(tvalid),
        .tready(tready), .tuser(tuser), .tlast(tlast), .tdata(tdata), .tdest(tdest),
        .tkeep(tkeep), .busy(busy), .frm_cnt(frm_cnt)
    );

    vid_strm_gen #(.WDT(W2), .HGT(H2), .DW(DW2), .NCH(1), .HBLK(0), .VBLK(0)) u_bar (
        .clk(clk), .rst_n(rst_n), .enb(enb2), .ptn_sel(ptn2), .tvalid(tvalid2),
        .tready(tready2), .tuser(tuser2), .tlast(tlast2), .tdata(tdata2), .tdest(tdest2),
        .tkeep(tkeep2), .busy(busy2), .frm_cnt(frm_cnt2)
    );

    typedef struct {
        logic [63:0] data;
        bit          user;
        bit          last;
        int          dest;
        int          frm;
        int          gap;
    } beat_t;

    beat_t q0[$], q1[$];
    int n_tests = 0, n_fail = 0;
    int beats0 = 0, beats1 = 0;
    int exp_frm0 = 0, exp_frm1 = 0;
    int bp = 0;
    logic [15:0] bars [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_pix(input int ptn, input int x, input int y,
                                            input int frm, input int wdt);
        case (ptn)
            0:       return 16'(x);
            1:       return 16'(y);
            2:       return ((((x / 8) + (y / 8)) % 2) == 1) ? 16'hFFFF : 16'h0000;
            3:       return bars[(x * 8) / wdt];
            4:       return 16'((x + y + frm) % 65536);
            default: return 16'h8080;
        endcase
    endfunction

    function automatic logic [63:0] rep(input logic [15:0] p, input int dw);
        logic [63:0] r = '0;
        for (int i = 0; i < dw / 16; i++) r[i*16 +: 16] = p;
        return r;
    endfunction

    // Expected beat stream of a run of nfr frames starting at channel 0.
    task automatic push_run(input int which, input int ptn, input int nfr, input int frm_base);
        int w = which ? W2 : WDT;
        int h = which ? H2 : HGT;
        int nc = which ? 1 : NCH;
        int hb = which ? 0 : HBLK;
        int vb = which ? 0 : VBLK;
        int dw = which ? DW2 : DW;
        beat_t b;
        for (int f = 0; f < nfr; f++)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++) begin
                    b.frm  = (frm_base + f / nc) % 65536;
                    b.data = rep(ref_pix(ptn, x, y, b.frm, w), dw);
                    b.user = (x == 0 && y == 0);
                    b.last = (x == w - 1);
                    b.dest = f % nc;
                    b.gap  = (f == 0 && y == 0 && x == 0) ? -1 : (x != 0) ? 0 : (y != 0) ? hb : vb;
                    if (which != 0) q1.push_back(b);
                    else            q0.push_back(b);
                end
    endtask

    initial begin : drv_ready
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (bp)
                0:       tready = 1'b1;
                1:       tready = ((ph % 4) == 0) || ((ph % 4) == 3);
                default: tready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    initial begin : mon0
        beat_t e;
        logic [63:0] held_v;
        bit held = 0;
        int gap = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 0;
                gap  = 0;
            end else begin
                if (held) chk("m0_stable", 64'({tvalid, tuser, tlast, tdest, tdata}), held_v);
                if (tvalid && tready) begin
                    beats0++;
                    if (q0.size() == 0) begin
                        chk("m0_extra_beat", 64'(tuser), 64'hDEAD);
                    end else begin
                        e = q0.pop_front();
                        chk("m0_data", 64'(tdata), e.data);
                        chk("m0_user", 64'(tuser), 64'(e.user));
                        chk("m0_last", 64'(tlast), 64'(e.last));
                        chk("m0_dest", 64'(tdest), 64'(e.dest));
                        chk("m0_keep", 64'(tkeep), 64'hF);
                        chk("m0_frm", 64'(frm_cnt), 64'(e.frm));
                        if (e.gap >= 0) chk("m0_gap", 64'(gap), 64'(e.gap));
                    end
                    gap = 0;
                end else if (!tvalid) begin
                    gap++;
                end
                held   = tvalid && !tready;
                held_v = 64'({tvalid, tuser, tlast, tdest, tdata});
            end
        end
    end

    initial begin : mon1
        beat_t e;
        int gap = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gap = 0;
            end else if (tvalid2 && tready2) begin
                beats1++;
                if (q1.size() == 0) begin
                    chk("m1_extra_beat", 64'(tuser2), 64'hDEAD);
                end else begin
                    e = q1.pop_front();
                    chk("m1_data", tdata2, e.data);
                    chk("m1_user", 64'(tuser2), 64'(e.user));
                    chk("m1_last", 64'(tlast2), 64'(e.last));
                    chk("m1_frm", 64'(frm_cnt2), 64'(e.frm));
                    if (e.gap >= 0) chk("m1_gap", 64'(gap), 64'(e.gap));
                end
                gap = 0;
            end else if (!tvalid2) begin
                gap++;
            end
        end
    end

    task automatic wait_cnt(input int which, input int tgt);
        int k;
        for (k = 0; k < 4000; k++) begin
            if (((which != 0) ? beats1 : beats0) >= tgt) break;
            @(posedge clk);
            #1;
        end
        if (k == 4000) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_beats%0d: timed out, got %0d beats expected %0d", which,
                     (which != 0) ? beats1 : beats0, tgt);
        end
    endtask

    task automatic wait_idle(input int which);
        int k;
        for (k = 0; k < 4000; k++) begin
            if (!((which != 0) ? busy2 : busy)) break;
            @(posedge clk);
            #1;
        end
        if (k == 4000) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle%0d: busy still 1 expected 0", which);
        end
    endtask

    // Start a run, drop enb on beat d of the last frame, wait for IDLE.
    task automatic run(input int which, input int ptn, input int nfr, input int d, input int bpm);
        int fpf  = (which != 0) ? W2 * H2 : WDT * HGT;
        int base = (which != 0) ? beats1 : beats0;
        push_run(which, ptn, nfr, (which != 0) ? exp_frm1 : exp_frm0);
        if (which != 0) begin
            ptn2 = 3'(ptn);
            enb2 = 1'b1;
        end else begin
            bp      = bpm;
            ptn_sel = 3'(ptn);
            enb     = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("first_vld", 64'((which != 0) ? tvalid2 : tvalid), 64'd1);
        chk("first_user", 64'((which != 0) ? tuser2 : tuser), 64'd1);
        wait_cnt(which, base + (nfr - 1) * fpf + d);
        if (which != 0) enb2 = 1'b0;
        else            enb  = 1'b0;
        wait_idle(which);
        bp = 0;
        if (which != 0) begin
            exp_frm1 = (exp_frm1 + nfr) % 65536;
            chk("end_frm1", 64'(frm_cnt2), 64'(exp_frm1));
            chk("end_q1", 64'(q1.size()), 64'd0);
        end else begin
            exp_frm0 = (exp_frm0 + nfr / NCH) % 65536;
            chk("end_frm0", 64'(frm_cnt), 64'(exp_frm0));
            chk("end_q0", 64'(q0.size()), 64'd0);
            chk("end_vld0", 64'(tvalid), 64'd0);
            chk("end_keep0", 64'(tkeep), 64'd0);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int base;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 64'(tvalid), 64'd0);
        chk("rst_user", 64'(tuser), 64'd0);
        chk("rst_last", 64'(tlast), 64'd0);
        chk("rst_data", 64'(tdata), 64'd0);
        chk("rst_dest", 64'(tdest), 64'd0);
        chk("rst_keep", 64'(tkeep), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frm", 64'(frm_cnt), 64'd0);
        chk("rst_vld2", 64'(tvalid2), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(0, 0, 2, 32, 0);   // geometry + channel round
        run(0, 1, 1, 10, 0);   // enable drop mid-frame
        run(0, 4, 2, 5, 1);    // back-pressure 1,0,0,1 with moving ramp
        run(0, 6, 1, 16, 0);   // constant pattern
        for (int r = 0; r < 4; r++)
            run(0, int'($urandom_range(0, 7)), int'($urandom_range(1, 3)),
                int'($urandom_range(1, 32)), int'($urandom_range(0, 2)));

        run(1, 3, 2, 8, 0);    // colour bars at WDT=16, zero blanking
        run(1, 2, 1, 8, 0);    // checker reaches x=8
        run(1, int'($urandom_range(0, 7)), 2, 20, 0);

        // Reset mid-line on beat 5 of a frame
        push_run(0, 0, 1, exp_frm0);
        ptn_sel = 3'd0;
        enb     = 1'b1;
        base    = beats0;
        wait_cnt(0, base + 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(tvalid), 64'd0);
        chk("mid_rst_frm", 64'(frm_cnt), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        q0.delete();
        exp_frm0 = 0;
        push_run(0, 0, 1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_vld", 64'(tvalid), 64'd1);
        chk("post_rst_user", 64'(tuser), 64'd1);
        chk("post_rst_dest", 64'(tdest), 64'd0);
        chk("post_rst_data", 64'(tdata), 64'd0);
        base = beats0;
        wait_cnt(0, base + 3);
        enb = 1'b0;
        wait_idle(0);
        chk("post_rst_q0", 64'(q0.size()), 64'd0);
        chk("post_rst_frm", 64'(frm_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vid_strm_gen.md
# vid_strm_gen

Parametrised AXI4-Stream video source for the dvp capture path. It replaces the fixed 640x480 single-stream CSI-2 receiver model with configurable geometry, data width, channel count, blanking and test pattern. It honours `tready` back-pressure and emits interleaved frames for several virtual channels. It sits in front of the `dvp` `v1`/`v2` stream inputs in simulation and is synthesizable as an on-chip pattern source.

## Interface
Parameters:
- `WDT`, 640: beats per line (one pixel per beat).
- `HGT`, 480: lines per frame.
- `DW`, 32: `tdata` width; must be a multiple of 16.
- `NCH`, 1: virtual channels, 1..16, emitted round-robin.
- `HBLK`, 16: idle cycles after each line except the last line of a frame; 0 allowed.
- `VBLK`, 1000: idle cycles after each frame; 0 allowed.

Ports (clock and reset first):
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enb`, in, 1: run request.
- `ptn_sel`, in, 3: pattern select; latched at frame start.
- `tvalid`, out, 1: AXIS valid.
- `tready`, in, 1: AXIS ready.
- `tuser`, out, 1: start of frame, high on the first beat of each frame.
- `tlast`, out, 1: end of line, high on the last beat of each line.
- `tdata`, out, DW: pixel data.
- `tdest`, out, 4: channel index.
- `tkeep`, out, DW/8: all ones while `tvalid` is high, otherwise 0.
- `busy`, out, 1: high whenever the block is not in IDLE.
- `frm_cnt`, out, 16: completed frame rounds. Increments once per round of NCH frames and wraps at 0xFFFF -> 0.

## Operation
State machine: IDLE, ACTIVE, HBLANK, VBLANK.
- **IDLE**, `enb`=1: go to ACTIVE with x=0, y=0, ch=0. Latch `ptn_sel`.
- **ACTIVE**: a beat transfers when `tvalid` and `tready` are both high.
  - Transfer with x<WDT-1: x+1.
  - Transfer with x=WDT-1 and y<HGT-1: go to HBLANK, or straight to the next line if HBLK=0.
  - Transfer with x=WDT-1 and y=HGT-1: go to VBLANK, or skip it if VBLK=0.
- **HBLANK**: count HBLK cycles, then x=0, y+1, ACTIVE.
- **VBLANK**: count VBLK cycles, then advance the channel.
  - ch=NCH-1: ch wraps to 0 and `frm_cnt`+1.
  - After the channel update, `enb`=1 -> ACTIVE with a new `ptn_sel` latch; `enb`=0 -> IDLE.
- `enb` is examined only in IDLE and at the end of VBLANK. Dropping `enb` mid-frame lets the current frame finish, including its VBLANK.
- AXIS rules:
  - Once `tvalid` is high, `tvalid`, `tdata`, `tuser`, `tlast` and `tdest` stay stable until the handshake.
  - `tvalid` is never high in HBLANK, VBLANK or IDLE.
- Pixel value `pix[15:0]`, replicated DW/16 times into `tdata`:
  - 0 = horizontal ramp, x[15:0].
  - 1 = vertical ramp, y[15:0].
  - 2 = checker, 0xFFFF when x[3]^y[3] is 1, else 0x0000.
  - 3 = colour bars, bar index = x*8/WDT, value from an 8-entry table.
  - 4 = moving ramp, x+y+`frm_cnt`, modulo 2^16.
  - 5..7 = constant 0x8080.
- `tdest` = ch, zero-extended to 4 bits.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; x, y, ch and the blank counter 0; `frm_cnt` 0.
  - LFSR seed 0xACE1.
- All outputs are registered.
- The edge that samples IDLE with `enb`=1 also raises `tvalid` with `tuser`=1 and x=0. There is no extra latency.
- Each transfer edge presents the next beat. `tvalid` stays high across a line when `tready` is held high.
- After a line, `tvalid` is low for exactly HBLK cycles. After a frame, `tvalid` is low for exactly VBLK cycles.
- `frm_cnt` updates on the edge that leaves VBLANK for ch=NCH-1.
- Reset asserted mid-frame: everything clears asynchronously. A partial frame is not completed.

## Configuration
- `VID_STRM_GEN_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - In ACTIVE, when the next beat is about to be presented and lfsr[1:0]==0, `tvalid` is held low for one cycle first.
  - An asserted, un-accepted `tvalid` is never withdrawn.
- Not defined: no LFSR logic is present, and `tvalid` is continuous within a line.

## Structure
- Package `vid_strm_pkg`: state enum, pattern-select encodings, 8-entry colour-bar table, LFSR seed and taps.
- Sub-module `vid_ptn_pix`: combinational function of (ptn, x, y, frm_cnt) to `pix[15:0]`.
- Top level holds the FSM, counters, AXIS output register and the optional LFSR.

## Test plan
Bench parameters WDT=8, HGT=4, HBLK=2, VBLK=5, NCH=2, `tready`=1.
- **Geometry:** `enb`=1, `ptn_sel`=0 for one round.
  - Frame of 32 beats; `tlast` on beats 8, 16, 24, 32; `tuser` only on beat 1.
  - `tdata` = 0x00000000..0x00070007 per line.
  - 2 idle cycles between lines, 5 after the frame.
- **Channels:** two frames with `tdest` 0 then 1.
  - `frm_cnt` goes 0->1 only after the second VBLANK.
- **Back-pressure:** `tready` toggles 1,0,0,1 repeatedly.
  - Outputs are stable during the low cycles.
  - Beat sequence is identical to the `tready`=1 case; no loss or duplication.
- **Enable drop:** `enb`->0 on beat 10.
  - The frame completes all 32 beats plus VBLANK, then `busy`=0.
  - No beat has `tuser` afterwards.
- **Patterns:**
  - `ptn_sel`=3, WDT=16: `tdata` changes every 2 beats through the table.
  - `ptn_sel`=2: beat (x=8,y=0) = 0xFFFFFFFF.
  - `ptn_sel`=6: every beat is 0x80808080.
- **Reset mid-line:** `rst_n` low at beat 5 -> `tvalid`=0 and `frm_cnt`=0 immediately. After release with `enb`=1, the first beat has `tuser`=1, x=0, `tdest`=0.
